// File: rtl/mac16_pkg.sv
// Shared definitions for the MAC16 arbiter: op codes, pipeline latency,
// in-flight tag layout, arbiter lock states and SB_MAC16 constants for the
// registered 16x16 multiply-add mode.
package mac16_pkg;

   localparam int unsigned MAC16_LATENCY = 2;

   localparam logic OP_MUL    = 1'b0;
   localparam logic OP_MULADD = 1'b1;

   // Wide enough for the largest supported NUM_REQ (8)
   localparam int unsigned TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
      logic                op;
   } mac_tag_t;

   typedef enum logic {
      ARB_RR,
      ARB_LOCKED
   } arb_state_e;

   // SB_MAC16 configuration: registered A/B/C/D inputs, second 16x16
   // pipeline register, 32-bit adder summing the product with {C,D}
   localparam logic       SB_NEG_TRIGGER           = 1'b0;
   localparam logic       SB_A_REG                 = 1'b1;
   localparam logic       SB_B_REG                 = 1'b1;
   localparam logic       SB_C_REG                 = 1'b1;
   localparam logic       SB_D_REG                 = 1'b1;
   localparam logic       SB_TOP_8X8_MULT_REG      = 1'b0;
   localparam logic       SB_BOT_8X8_MULT_REG      = 1'b0;
   localparam logic       SB_PIPE_16X16_MULT_REG1  = 1'b0;
   localparam logic       SB_PIPE_16X16_MULT_REG2  = 1'b1;
   localparam logic [1:0] SB_TOPOUTPUT_SELECT      = 2'b00;
   localparam logic [1:0] SB_TOPADDSUB_LOWERINPUT  = 2'b10;
   localparam logic       SB_TOPADDSUB_UPPERINPUT  = 1'b1;
   localparam logic [1:0] SB_TOPADDSUB_CARRYSELECT = 2'b10;
   localparam logic [1:0] SB_BOTOUTPUT_SELECT      = 2'b00;
   localparam logic [1:0] SB_BOTADDSUB_LOWERINPUT  = 2'b10;
   localparam logic       SB_BOTADDSUB_UPPERINPUT  = 1'b1;
   localparam logic [1:0] SB_BOTADDSUB_CARRYSELECT = 2'b00;
   localparam logic       SB_MODE_8X8              = 1'b0;

   // Extend a 16-bit operand to 32 bits, sign or zero per sgn
   function automatic logic [31:0] ext16(input logic [15:0] v, input logic sgn);
      return sgn ? {{16{v[15]}}, v} : {16'h0000, v};
   endfunction

endpackage

// File: rtl/mac16_core.sv
// Two-cycle 16x16 multiply with optional 32-bit addend: o = a*b (+ c32).
// Build option: define MAC16_CORE_SB_MAC16 to map onto the iCE40 SB_MAC16
// primitive; otherwise a behavioural model with identical timing is used.
module mac16_core
   import mac16_pkg::*;
#(
   parameter int SIGNED = 0
) (
   input  logic        clk,
   input  logic        ce,
   input  logic [15:0] a,
   input  logic [15:0] b,
   input  logic [31:0] c32,
   input  logic        addsub_en,
   output logic [31:0] o
);

`ifdef MAC16_CORE_SB_MAC16
   logic [31:0] c_d1;

   // Addend is delayed one cycle so that, after the C/D input registers, it
   // meets the product leaving the second multiplier pipeline register
   always_ff @(posedge clk) begin
      if (ce) c_d1 <= addsub_en ? c32 : '0;
   end

   SB_MAC16 #(
      .NEG_TRIGGER              (SB_NEG_TRIGGER),
      .A_REG                    (SB_A_REG),
      .B_REG                    (SB_B_REG),
      .C_REG                    (SB_C_REG),
      .D_REG                    (SB_D_REG),
      .TOP_8x8_MULT_REG         (SB_TOP_8X8_MULT_REG),
      .BOT_8x8_MULT_REG         (SB_BOT_8X8_MULT_REG),
      .PIPELINE_16x16_MULT_REG1 (SB_PIPE_16X16_MULT_REG1),
      .PIPELINE_16x16_MULT_REG2 (SB_PIPE_16X16_MULT_REG2),
      .TOPOUTPUT_SELECT         (SB_TOPOUTPUT_SELECT),
      .TOPADDSUB_LOWERINPUT     (SB_TOPADDSUB_LOWERINPUT),
      .TOPADDSUB_UPPERINPUT     (SB_TOPADDSUB_UPPERINPUT),
      .TOPADDSUB_CARRYSELECT    (SB_TOPADDSUB_CARRYSELECT),
      .BOTOUTPUT_SELECT         (SB_BOTOUTPUT_SELECT),
      .BOTADDSUB_LOWERINPUT     (SB_BOTADDSUB_LOWERINPUT),
      .BOTADDSUB_UPPERINPUT     (SB_BOTADDSUB_UPPERINPUT),
      .BOTADDSUB_CARRYSELECT    (SB_BOTADDSUB_CARRYSELECT),
      .MODE_8x8                 (SB_MODE_8X8),
      .A_SIGNED                 (1'(SIGNED != 0)),
      .B_SIGNED                 (1'(SIGNED != 0))
   ) u_mac (
      .CLK        (clk),
      .CE         (ce),
      .C          (c_d1[31:16]),
      .A          (a),
      .B          (b),
      .D          (c_d1[15:0]),
      .AHOLD      (1'b0),
      .BHOLD      (1'b0),
      .CHOLD      (1'b0),
      .DHOLD      (1'b0),
      .IRSTTOP    (1'b0),
      .IRSTBOT    (1'b0),
      .ORSTTOP    (1'b0),
      .ORSTBOT    (1'b0),
      .OLOADTOP   (1'b0),
      .OLOADBOT   (1'b0),
      .ADDSUBTOP  (1'b0),
      .ADDSUBBOT  (1'b0),
      .OHOLDTOP   (1'b0),
      .OHOLDBOT   (1'b0),
      .CI         (1'b0),
      .ACCUMCI    (1'b0),
      .SIGNEXTIN  (1'b0),
      .O          (o),
      .CO         (),
      .ACCUMCO    (),
      .SIGNEXTOUT ()
   );
`else
   localparam logic SGN = (SIGNED != 0);

   logic [15:0] a_r;
   logic [15:0] b_r;
   logic [31:0] c_r;
   logic [31:0] o_r;

   // Input register stage (A/B/C/D); a disabled addend is captured as zero
   always_ff @(posedge clk) begin
      if (ce) begin
         a_r <= a;
         b_r <= b;
         c_r <= addsub_en ? c32 : '0;
      end
   end

   // Product/accumulate stage; arithmetic wraps modulo 2^32
   always_ff @(posedge clk) begin
      if (ce) o_r <= ext16(a_r, SGN) * ext16(b_r, SGN) + c_r;
   end

   assign o = o_r;
`endif

endmodule

// File: rtl/mac16_arbiter.sv
// Round-robin arbiter sharing one MAC16 between NUM_REQ requesters with an
// id-tagged, back-pressured response port (fixed latency of two cycles).
// Build option: define MAC16_ARBITER_LOCK_EN to add req_lock, letting a
// granted requester park the arbiter on itself.
module mac16_arbiter
   import mac16_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int SIGNED  = 0,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ-1:0]    req_op,
   input  logic [NUM_REQ*16-1:0] req_a,
   input  logic [NUM_REQ*16-1:0] req_b,
   input  logic [NUM_REQ*32-1:0] req_c,
`ifdef MAC16_ARBITER_LOCK_EN
   input  logic [NUM_REQ-1:0]    req_lock,
`endif
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [ID_W-1:0]       rsp_id,
   output logic [31:0]           rsp_result,
   output logic                  busy
);

   localparam int unsigned LAST = MAC16_LATENCY - 1;

   mac_tag_t        tag_q [MAC16_LATENCY];
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] ptr_nxt;
   logic [ID_W-1:0] base_ptr;
   logic [ID_W-1:0] gnt_id;
   logic [ID_W-1:0] idx;
   logic            gnt_found;
   logic            stall;
   logic            hs;
   logic            mac_ce;
   logic [15:0]     mac_a;
   logic [15:0]     mac_b;
   logic [31:0]     mac_c;
   logic            mac_add;
   logic            mac_op;
   logic [31:0]     mac_o;
   logic            tag_unused;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] p);
      if (int'(p) == NUM_REQ - 1) return '0;
      return p + 1'b1;
   endfunction

   assign stall  = tag_q[LAST].valid & ~rsp_ready;
   assign mac_ce = ~stall;

   // Round-robin search for the first valid requester starting at base_ptr
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = base_ptr;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
         idx = wrap_inc(idx);
      end
   end

   // Grant is withheld while the response port is stalled or in reset
   always_comb begin
      req_ready = '0;
      if (gnt_found && !stall && reset_n) req_ready[gnt_id] = 1'b1;
   end

   assign hs = |(req_valid & req_ready);

   // Route the winner's operands to the MAC
   always_comb begin
      mac_a   = '0;
      mac_b   = '0;
      mac_c   = '0;
      mac_op  = OP_MUL;
      mac_add = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == gnt_id) begin
            mac_a   = req_a[i*16 +: 16];
            mac_b   = req_b[i*16 +: 16];
            mac_c   = req_c[i*32 +: 32];
            mac_op  = req_op[i];
            mac_add = hs && (req_op[i] == OP_MULADD);
         end
      end
   end

`ifdef MAC16_ARBITER_LOCK_EN
   arb_state_e      arb_q;
   arb_state_e      arb_d;
   logic [ID_W-1:0] lock_id_q;
   logic [ID_W-1:0] lock_id_d;

   // Search start: the lock owner while it stays valid, else just past it
   always_comb begin
      base_ptr = rr_ptr;
      if (arb_q == ARB_LOCKED)
         base_ptr = req_valid[lock_id_q] ? lock_id_q : wrap_inc(lock_id_q);
   end

   // Lock FSM and pointer update; a locking handshake leaves the pointer parked
   always_comb begin
      arb_d     = arb_q;
      lock_id_d = lock_id_q;
      ptr_nxt   = rr_ptr;
      if (hs) begin
         if (req_lock[gnt_id]) begin
            arb_d     = ARB_LOCKED;
            lock_id_d = gnt_id;
         end else begin
            arb_d   = ARB_RR;
            ptr_nxt = wrap_inc(gnt_id);
         end
      end else if (arb_q == ARB_LOCKED && !stall && !req_valid[lock_id_q]) begin
         arb_d   = ARB_RR;
         ptr_nxt = wrap_inc(lock_id_q);
      end
   end

   // Lock state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         arb_q     <= ARB_RR;
         lock_id_q <= '0;
      end else begin
         arb_q     <= arb_d;
         lock_id_q <= lock_id_d;
      end
   end
`else
   assign base_ptr = rr_ptr;
   assign ptr_nxt  = hs ? wrap_inc(gnt_id) : rr_ptr;
`endif

   // Round-robin pointer (ptr_nxt already holds during a stall)
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rr_ptr <= '0;
      else          rr_ptr <= ptr_nxt;
   end

   // In-flight tags travel alongside the MAC data and freeze with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MAC16_LATENCY; i++) tag_q[i] <= '0;
      end else if (!stall) begin
         tag_q[0] <= '{valid: hs, id: TAG_ID_W'(gnt_id), op: mac_op};
         for (int unsigned i = 1; i < MAC16_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      end
   end

   mac16_core #(
      .SIGNED (SIGNED)
   ) u_core (
      .clk       (clk),
      .ce        (mac_ce),
      .a         (mac_a),
      .b         (mac_b),
      .c32       (mac_c),
      .addsub_en (mac_add),
      .o         (mac_o)
   );

   assign rsp_valid  = tag_q[LAST].valid;
   assign rsp_id     = tag_q[LAST].id[ID_W-1:0];
   // MAC data registers carry no reset, so the idle result is forced to zero
   assign rsp_result = rsp_valid ? mac_o : '0;

   // Busy while any stage holds an op
   always_comb begin
      busy = 1'b0;
      for (int unsigned i = 0; i < MAC16_LATENCY; i++) busy = busy | tag_q[i].valid;
   end

   // Tag fields kept for debug visibility but not needed at the output
   always_comb begin
      tag_unused = 1'b0;
      for (int unsigned i = 0; i < MAC16_LATENCY; i++) tag_unused = tag_unused ^ (^tag_q[i]);
   end

endmodule

// File: tb/tb_mac16_arbiter.sv
// Self-checking bench for mac16_arbiter: unsigned and signed instances share
// stimulus and are compared against a queue-based reference model.
module tb_mac16_arbiter;

   localparam int N = 4;

   logic           clk = 1'b0;
   logic           reset_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_op = '0;
   logic [N*16-1:0] req_a = '0;
   logic [N*16-1:0] req_b = '0;
   logic [N*32-1:0] req_c = '0;
   logic           rsp_ready = 1'b1;
`ifdef MAC16_ARBITER_LOCK_EN
   logic [N-1:0]   req_lock = '0;
`endif

   logic [N-1:0] ready_u, ready_s;
   logic         rv_u, rv_s;
   logic [1:0]   id_u, id_s;
   logic [31:0]  res_u, res_s;
   logic         busy_u, busy_s;

   int total = 0;
   int bad = 0;

   typedef struct {
      int          id;
      logic [31:0] ru;
      logic [31:0] rs;
      int          age;
   } op_t;

   op_t          q[$];
   int           ptr = 0;
   bit           lock_on = 1'b0;
   int           lock_id = 0;
   logic [N-1:0] last_ready;

   mac16_arbiter #(.NUM_REQ(N), .SIGNED(0)) dut_u (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_u),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
`ifdef MAC16_ARBITER_LOCK_EN
      .req_lock(req_lock),
`endif
      .rsp_valid(rv_u), .rsp_ready(rsp_ready), .rsp_id(id_u),
      .rsp_result(res_u), .busy(busy_u)
   );

   mac16_arbiter #(.NUM_REQ(N), .SIGNED(1)) dut_s (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(ready_s),
      .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_c(req_c),
`ifdef MAC16_ARBITER_LOCK_EN
      .req_lock(req_lock),
`endif
      .rsp_valid(rv_s), .rsp_ready(rsp_ready), .rsp_id(id_s),
      .rsp_result(res_s), .busy(busy_s)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   // Plain arithmetic reference: integer product plus optional addend, low 32 bits
   function automatic logic [31:0] ref_res(input logic [15:0] a, input logic [15:0] b,
                                          input logic [31:0] c, input logic op, input bit sgn);
      longint sa, sb, r;
      sa = sgn ? longint'($signed(a)) : longint'(a);
      sb = sgn ? longint'($signed(b)) : longint'(b);
      r  = sa * sb + (op ? longint'(c) : 64'sd0);
      return r[31:0];
   endfunction

   // One clock cycle: drive, check against the model, then advance the model
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] op, input logic rr,
                       input logic [N-1:0] lk);
      bit           found, stall, exp_rv;
      int           g, base, k2;
      logic [N-1:0] exp_ready;
      logic [15:0]  oa, ob;
      logic [31:0]  oc;
      @(negedge clk);
      req_valid = v;
      req_op    = op;
      rsp_ready = rr;
`ifdef MAC16_ARBITER_LOCK_EN
      req_lock  = lk;
`endif
      #1;
      exp_rv = (q.size() > 0) && (q[0].age >= 2);
      stall  = exp_rv && !rr;
      chk("rsp_valid_u", 32'(rv_u), 32'(exp_rv));
      chk("rsp_valid_s", 32'(rv_s), 32'(exp_rv));
      chk("busy_u", 32'(busy_u), 32'(q.size() > 0));
      chk("busy_s", 32'(busy_s), 32'(q.size() > 0));
      if (exp_rv) begin
         chk("rsp_id_u", 32'(id_u), 32'(q[0].id));
         chk("rsp_id_s", 32'(id_s), 32'(q[0].id));
         chk("rsp_result_u", res_u, q[0].ru);
         chk("rsp_result_s", res_s, q[0].rs);
      end
      found = 1'b0;
      g = 0;
      exp_ready = '0;
      if (!stall) begin
         base = lock_on ? (v[lock_id] ? lock_id : (lock_id + 1) % N) : ptr;
         for (int k = 0; k < N; k++) begin
            k2 = (base + k) % N;
            if (!found && v[k2]) begin
               found = 1'b1;
               g = k2;
            end
         end
         if (found) exp_ready[g] = 1'b1;
      end
      chk("req_ready_u", 32'(ready_u), 32'(exp_ready));
      chk("req_ready_s", 32'(ready_s), 32'(exp_ready));
      last_ready = ready_u;
      oa = req_a[g*16 +: 16];
      ob = req_b[g*16 +: 16];
      oc = req_c[g*32 +: 32];
      @(posedge clk);
      #1;
      if (!stall) begin
         if (exp_rv) void'(q.pop_front());
         foreach (q[i]) q[i].age++;
         if (found) begin
            q.push_back('{g, ref_res(oa, ob, oc, op[g], 1'b0), ref_res(oa, ob, oc, op[g], 1'b1), 1});
            if (lk[g]) begin
               lock_on = 1'b1;
               lock_id = g;
            end else begin
               lock_on = 1'b0;
               ptr = (g + 1) % N;
            end
         end else if (lock_on && !v[lock_id]) begin
            lock_on = 1'b0;
            ptr = (lock_id + 1) % N;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = '0;
      @(posedge clk);
      #1;
      chk("rst_rsp_valid", 32'(rv_u), 32'd0);
      chk("rst_busy", 32'(busy_u), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      ptr = 0;
      lock_on = 1'b0;
   endtask

   task automatic rand_operands();
      req_a = {$urandom(), $urandom()};
      req_b = {$urandom(), $urandom()};
      req_c = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   initial begin
      logic [N-1:0] rlk;

      // Reset state, with all requesters asking during reset
      #1 reset_n = 1'b0;
      req_valid = '1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_ready_u", 32'(ready_u), 32'd0);
      chk("reset_ready_s", 32'(ready_s), 32'd0);
      chk("reset_rsp_valid", 32'(rv_u), 32'd0);
      chk("reset_rsp_id", 32'(id_u), 32'd0);
      chk("reset_rsp_result", res_u, 32'd0);
      chk("reset_busy", 32'(busy_s), 32'd0);
      @(negedge clk);
      req_valid = '0;
      reset_n = 1'b1;
      step('0, '0, 1'b1, '0);

      // Single MUL from requester 0: result two cycles after the grant
      req_a[15:0] = 16'h1234;
      req_b[15:0] = 16'h0010;
      step(4'b0001, 4'b0000, 1'b1, '0);
      step('0, '0, 1'b1, '0);
      chk("single_valid", 32'(rv_u), 32'd1);
      chk("single_id", 32'(id_u), 32'd0);
      chk("single_result_u", res_u, 32'h0001_2340);
      chk("single_result_s", res_s, 32'h0001_2340);
      step('0, '0, 1'b1, '0);

      // MULADD with a negative operand in the signed instance
      req_a[15:0] = 16'hFFFF;
      req_b[15:0] = 16'h0003;
      req_c[31:0] = 32'h0000_0010;
      step(4'b0001, 4'b0001, 1'b1, '0);
      step('0, '0, 1'b1, '0);
      chk("muladd_result_s", res_s, 32'h0000_000D);
      chk("muladd_result_u", res_u, 32'h0003_000D);
      step('0, '0, 1'b1, '0);

      // Reset with an op in flight: dropped, pointer back to 0
      step(4'b0010, '0, 1'b1, '0);
      do_reset();
      repeat (4) step('0, '0, 1'b1, '0);

      // Fairness: all valid for 8 cycles
      for (int k = 0; k < 8; k++) begin
         rand_operands();
         step('1, 4'($urandom_range(0, 15)), 1'b1, '0);
         chk("fair_order", 32'(last_ready), 32'(4'b0001 << (k % 4)));
      end
      repeat (3) step('0, '0, 1'b1, '0);

      // Back-pressure with two ops in flight
      rand_operands();
      step(4'b0010, 4'b0010, 1'b0, '0);
      step(4'b0100, 4'b0000, 1'b0, '0);
      for (int k = 0; k < 5; k++) begin
         step('1, '0, 1'b0, '0);
         chk("stall_ready", 32'(last_ready), 32'd0);
      end
      repeat (3) step('0, '0, 1'b1, '0);

`ifdef MAC16_ARBITER_LOCK_EN
      // Lock: requester 2 parks the arbiter while requester 0 waits
      step(4'b0010, '0, 1'b1, '0);
      for (int k = 0; k < 4; k++) begin
         rand_operands();
         step(4'b0101, '0, 1'b1, 4'b0100);
         chk("lock_grant", 32'(last_ready), 32'h4);
      end
      step(4'b0001, '0, 1'b1, '0);
      chk("lock_release", 32'(last_ready), 32'h1);
      repeat (3) step('0, '0, 1'b1, '0);
`endif

      // Randomized traffic
      for (int k = 0; k < 400; k++) begin
         rand_operands();
         rlk = '0;
`ifdef MAC16_ARBITER_LOCK_EN
         rlk = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
`endif
         step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 3) != 0), rlk);
      end
      repeat (4) step('0, '0, 1'b1, '0);
      chk("drained_busy", 32'(busy_u), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
